// File: rtl/hypercorex_pkg.sv
// Shared hypercorex definitions: default widths and the instruction fetch FSM encoding.
package hypercorex_pkg;

  localparam int unsigned InstMemAddrWidthDef = 32;
  localparam int unsigned InstWidthDef        = 32;
  localparam int unsigned FetchCountWidthDef  = 32;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_RUN   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_control.sv
// Instruction fetch sequencer: walks the PC through instruction memory, handles jumps,
// debug single-step and decoder back-pressure, and reports completion.
module inst_fetch_control
  import hypercorex_pkg::*;
#(
  parameter int unsigned InstMemAddrWidth = InstMemAddrWidthDef,
  parameter int unsigned InstWidth        = InstWidthDef,
  parameter int unsigned FetchCountWidth  = FetchCountWidthDef
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        start_i,
  input  logic                        dbg_en_i,
  input  logic                        dbg_step_i,
  input  logic                        loop_en_i,
  input  logic [InstMemAddrWidth-1:0] inst_last_addr_i,
  input  logic                        inst_jump_i,
  input  logic [InstMemAddrWidth-1:0] inst_jump_addr_i,
  input  logic                        inst_loop_done_i,
  output logic [InstMemAddrWidth-1:0] inst_pc_o,
  output logic                        inst_rd_en_o,
  input  logic [InstWidth-1:0]        inst_rd_data_i,
  output logic [InstWidth-1:0]        inst_o,
  output logic                        inst_valid_o,
  input  logic                        inst_ready_i,
  output logic                        loop_en_o,
  output logic                        loop_stall_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [FetchCountWidth-1:0]  fetch_count_o
);

  if_state_e                   state_q, state_d;
  logic [InstMemAddrWidth-1:0] pc_q;
  logic [FetchCountWidth-1:0]  count_q;
  logic                        valid_q;

  logic run, adv, end_cond, accept, launch;

  assign run      = (state_q == IF_RUN);
  assign accept   = valid_q && inst_ready_i;
  assign adv      = run && (!valid_q || inst_ready_i) && (!dbg_en_i || dbg_step_i);
  assign end_cond = loop_en_i ? inst_loop_done_i : (pc_q == inst_last_addr_i);
  assign launch   = (state_q == IF_IDLE) && start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A jump in the same cycle as the end condition keeps the sequencer running.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IF_IDLE;
    end else begin
      unique case (state_q)
        IF_IDLE:  if (start_i) state_d = IF_RUN;
        IF_RUN:   if (adv && !inst_jump_i && end_cond) state_d = IF_DRAIN;
        IF_DRAIN: if (accept) state_d = IF_IDLE;
        default:  state_d = IF_IDLE;
      endcase
    end
  end

  always_comb begin
    inst_rd_en_o = adv;
    loop_en_o    = run;
    loop_stall_o = run && !adv;
    busy_o       = (state_q != IF_IDLE);
    done_o       = (state_q == IF_DRAIN) && accept && !clr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      pc_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (launch) begin
      pc_q    <= '0;
      count_q <= '0;
    end else if (adv) begin
      valid_q <= 1'b1;
      if (count_q != '1) count_q <= count_q + FetchCountWidth'(1);
      if (inst_jump_i) begin
        pc_q <= inst_jump_addr_i;
      end else if (!end_cond) begin
        pc_q <= pc_q + InstMemAddrWidth'(1);
      end
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign inst_pc_o     = pc_q;
  assign inst_o        = inst_rd_data_i;
  assign inst_valid_o  = valid_q;
  assign fetch_count_o = count_q;

endmodule
